// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq
//   Runs one 128-bit AES decryption state through InvMixColumns on a shared
//   column datapath, COLS_PER_CYCLE columns per clock. It holds one state at
//   a time and uses valid/ready handshakes on both the input and the output.
//
// Parameters
//   COLS_PER_CYCLE : column helpers per cycle (1, 2 or 4). Processing takes
//                    4/COLS_PER_CYCLE cycles.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   in_valid   : in_state is valid
//   in_ready   : the block accepts in_state this cycle (IDLE only)
//   in_state   : input state; column c = bits [127-32c -: 32], byte 0 in the MSB
//   in_bypass  : present only when IMC_BYPASS_EN is defined. It is sampled
//                with the input handshake and passes the state through
//                unmodified.
//   out_valid  : out_state is valid (DONE)
//   out_ready  : the downstream stage accepts out_state
//   out_state  : InvMixColumns(in_state). It is held until the next completion.
//   busy       : high in BUSY or DONE
//
// Build option
//   IMC_BYPASS_EN : adds in_bypass for the final decryption round, which has
//                   no InvMixColumns.

module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef IMC_BYPASS_EN
  input  logic         in_bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned STATE_W  = 128;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned NUM_COLS = 4;
  localparam logic [1:0]  LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);
  localparam logic [1:0]  IDX_STEP = 2'(COLS_PER_CYCLE);

  // Reject unsupported helper counts at elaboration.
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns. Each coefficient is built from the
  // x2/x4/x8 multiples: 9 = 8+1, b = 8+2+1, d = 8+4+1, e = 8+4+2.
  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] col);
    logic [7:0] a   [4];
    logic [7:0] m2  [4];
    logic [7:0] m4  [4];
    logic [7:0] m8  [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[COL_W-1-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  fsm_t               r_fsm;
  fsm_t               w_fsm_nx;
  logic [1:0]         r_col_idx;
  logic [1:0]         w_col_idx_nx;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nx;
  logic [STATE_W-1:0] r_out_state;
  logic [STATE_W-1:0] w_out_state_nx;
  logic               r_byp;
  logic               w_byp_nx;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_accept;
  logic               w_bypass;
  logic [COL_W-1:0]   w_cols    [NUM_COLS];
  logic [COL_W-1:0]   w_cols_nx [NUM_COLS];
  logic [COL_W-1:0]   w_mix     [COLS_PER_CYCLE];
  logic [STATE_W-1:0] w_wb_state;

`ifdef IMC_BYPASS_EN
  assign w_bypass = in_bypass;
`else
  assign w_bypass = 1'b0;
`endif

  // in_ready is only ever high in IDLE.
  assign w_accept = in_valid & r_in_ready;

  // Split the working state into columns.
  for (genvar c = 0; c < int'(NUM_COLS); c++) begin : g_cols
    assign w_cols[c] = r_state[STATE_W-1-COL_W*c -: COL_W];
  end

  // Column helpers. Helper j works on column col_idx+j.
  for (genvar j = 0; j < int'(COLS_PER_CYCLE); j++) begin : g_helper
    assign w_mix[j] = inv_mix_col(w_cols[r_col_idx + 2'(j)]);
  end

  // Write the processed columns back in place.
  always_comb begin
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      w_cols_nx[c] = w_cols[c];
    end
    for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
      w_cols_nx[r_col_idx + 2'(j)] = w_mix[j];
    end
    w_wb_state = {w_cols_nx[0], w_cols_nx[1], w_cols_nx[2], w_cols_nx[3]};
  end

  // Next-state logic and datapath updates.
  always_comb begin
    w_fsm_nx       = r_fsm;
    w_col_idx_nx   = r_col_idx;
    w_state_nx     = r_state;
    w_out_state_nx = r_out_state;
    w_byp_nx       = r_byp;
    case (r_fsm)
      S_IDLE: begin
        w_col_idx_nx = 2'd0;
        if (w_accept) begin
          w_state_nx = in_state;
          w_byp_nx   = w_bypass;
          w_fsm_nx   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_byp) begin
          // A bypassed state spends one cycle here so its latency matches
          // the single-pass case. The state is not modified.
          w_fsm_nx       = S_DONE;
          w_out_state_nx = r_state;
          w_col_idx_nx   = 2'd0;
        end else begin
          w_state_nx   = w_wb_state;
          w_col_idx_nx = r_col_idx + IDX_STEP;
          if (r_col_idx == LAST_IDX) begin
            w_fsm_nx       = S_DONE;
            w_out_state_nx = w_wb_state;
            w_col_idx_nx   = 2'd0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_fsm_nx = S_IDLE;
          w_byp_nx = 1'b0;
        end
      end
      default: begin
        w_fsm_nx     = S_IDLE;
        w_col_idx_nx = 2'd0;
      end
    endcase
  end

  // State register. The flags are registered from the next state so that
  // every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_col_idx   <= 2'd0;
      r_state     <= '0;
      r_out_state <= '0;
      r_byp       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nx;
      r_col_idx   <= w_col_idx_nx;
      r_state     <= w_state_nx;
      r_out_state <= w_out_state_nx;
      r_byp       <= w_byp_nx;
      r_in_ready  <= (w_fsm_nx == S_IDLE);
      r_out_valid <= (w_fsm_nx == S_DONE);
      r_busy      <= (w_fsm_nx != S_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_out_state;
  assign busy      = r_busy;

endmodule
